// File: rtl/pixel_stream_packer.sv
// Packs an 8-bit pixel stream into 32-bit AXI4-Stream words, four pixels per word.
// The last word of each frame carries tlast and a tkeep for its filled lanes.
module pixel_stream_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        i_data_valid,
  input  logic [7:0]  i_data,
  output logic        o_data_ready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        o_frame_done
);

  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);

  logic [1:0]    lane_reg;
  logic [CW-1:0] pix_cnt_reg;
  logic [23:0]   asm_reg;
  logic [31:0]   asm_ext;
  logic [31:0]   word_next;
  logic [3:0]    keep_next;
  logic          last_pix;
  logic          word_end;
  logic          accept;
  logic          complete;
  logic          out_hs;

  assign last_pix = (pix_cnt_reg == LAST_PIX);
  assign word_end = (lane_reg == 2'd3) || last_pix;
  assign out_hs   = m_axis_tvalid & m_axis_tready;

  // Only the word-completing byte can stall, and only while the output
  // register is occupied and not draining on this edge.
  assign o_data_ready = !(word_end && m_axis_tvalid && !m_axis_tready);
  assign accept       = i_data_valid & o_data_ready;
  assign complete     = accept & word_end;

  assign asm_ext = {8'h00, asm_reg};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (lane_reg == 2'(gi)) ? i_data : asm_ext[8*gi +: 8];
      assign keep_next[gi]        = (2'(gi) <= lane_reg);
    end
  endgenerate

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      lane_reg      <= 2'd0;
      pix_cnt_reg   <= '0;
      asm_reg       <= 24'h0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'h0;
      m_axis_tkeep  <= 4'h0;
      m_axis_tlast  <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      if (accept) begin
        pix_cnt_reg <= last_pix ? '0 : pix_cnt_reg + 1'b1;
        if (complete) begin
          lane_reg <= 2'd0;
          asm_reg  <= 24'h0;   // keeps unused lanes of the next partial word at zero
        end else begin
          lane_reg <= lane_reg + 2'd1;
          asm_reg  <= word_next[23:0];
        end
      end

      if (complete) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= word_next;
        m_axis_tkeep  <= keep_next;
        m_axis_tlast  <= last_pix;
      end else if (out_hs) begin
        m_axis_tvalid <= 1'b0;
      end

      o_frame_done <= out_hs & m_axis_tlast;
    end
  end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
Downstream neighbour of Edge_detector. Consumes its 8-bit pixel stream (o_data_valid/o_data/i_data_ready) and packs 4 pixels per 32-bit AXI4-Stream word for the S2MM DMA. Marks the final word of each frame with tlast and tkeep, and pulses a frame-done flag.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
FRAME_PIXELS, IMG_WIDTH*IMG_HEIGHT, derived; pixels per frame; must be >= 1

Ports:
axi_clk  input  1  single clock; all logic on rising edge
axi_reset_n  input  1  asynchronous, active-low reset
i_data_valid  input  1  pixel valid from Edge_detector o_data_valid
i_data  input  8  pixel from Edge_detector o_data
o_data_ready  output  1  pixel accept; drives Edge_detector i_data_ready
m_axis_tvalid  output  1  output word valid
m_axis_tdata  output  32  packed pixels, little-endian by arrival
m_axis_tkeep  output  4  valid byte lanes
m_axis_tlast  output  1  word holds the last pixel of the frame
m_axis_tready  input  1  downstream accept
o_frame_done  output  1  one-cycle pulse when the tlast word handshakes

Behaviour:
- Reset (async assert, sync-to-clock deassert use): m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, o_frame_done=0, lane counter=0, pixel counter=0, assembly register=0. Any partial word is discarded.
- Pixel accept = i_data_valid & o_data_ready. Input handshake = accept. Output handshake = m_axis_tvalid & m_axis_tready.
- Lane counter 0..3 selects the byte: lane k goes to bits [8k+7:8k]. The first pixel of a word lands in [7:0].
- Word complete = accept and (lane==3 or pixel counter==FRAME_PIXELS-1).
- On word complete, the assembled word (with the current byte) loads into the output register on the same edge. m_axis_tvalid=1 from the next cycle, giving 1-cycle latency from the completing byte. Lane returns to 0.
- Unused lanes of a partial final word are 0. tkeep has bit k=1 for each filled lane (e.g. 1 byte gives 4'b0001; full word gives 4'hF). tlast=1 only on the word containing pixel FRAME_PIXELS-1.
- Pixel counter increments per accept. It wraps to 0 after FRAME_PIXELS-1, so the next frame starts at lane 0.
- Output register: holds tdata/tkeep/tlast stable while tvalid=1 and tready=0. tvalid clears on handshake unless a new word loads on the same edge, in which case tvalid stays 1 with the new data.
- o_data_ready is 0 only when a word would complete (lane==3 or last pixel) while m_axis_tvalid=1 and m_axis_tready=0; otherwise it is 1. There is a combinational path from tready to ready, which is intended. Lanes 0-2 are never stalled.
- During reset, o_data_ready=1.
- o_frame_done=1 for exactly the cycle after the tlast word handshakes, and 0 otherwise.
- Sustained throughput is 1 pixel/cycle with tready=1, with no bubbles across word and frame boundaries.
- i_data_valid=0 mid-word: the partial word is held indefinitely with no timeout flush.

Test Plan:
1. Reset: hold axi_reset_n=0 with random inputs -> tvalid/tlast/tkeep/tdata/o_frame_done=0, o_data_ready=1. Release, with no input -> tvalid stays 0.
2. Basic pack: tready=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44, tdata=0x44332211, tkeep=4'hF, tlast=0, tvalid high for 1 cycle.
3. Backpressure: tready=0, stream 8 bytes 0x01..0x08 -> word 0x04030201 held stable; o_data_ready=0 while 0x08 is presented. Raise tready -> 0x04030201 then 0x08070605, no loss or duplication.
4. Partial last word: IMG_WIDTH=5, IMG_HEIGHT=1, bytes 0x01..0x05 -> words 0x04030201 (keep F, last 0) and 0x00000005 (keep 4'b0001, last 1). o_frame_done pulses once. A next byte 0xAA appears in lane 0.
5. Full frame at default parameters, tready toggling pseudo-randomly -> exactly 65536 words, tlast only on word 65535, one o_frame_done, payload matches the input byte sequence.
6. Reset mid-word after 2 bytes, then bytes 0xA0..0xA3 -> no word emitted for the discarded bytes; first output is 0xA3A2A1A0.
